flit_source: RTL

- Packet-generating channel transmitter: the upstream end of the two-phase req/ack flit channel that the router input port (rx) consumes.
- On a start pulse it emits one head flit followed by BODY_FLITS body flits. Each flit is announced by toggling ch_req and retired when ch_ack matches ch_req.
- Used as the traffic source in router and link testbenches, and as the injection port of a network endpoint.

---
 rtl/flit_source_if.sv | 9 +
 rtl/flit_source.sv | 71 +++++++
 2 files changed

// File: rtl/flit_source_if.sv
// Two-phase req/ack flit channel between a flit source and its receiver.
interface flit_source_if;
   logic       req;
   logic [7:0] flit;
   logic       ack;

   modport master (output req, output flit, input  ack);
   modport slave  (input  req, input  flit, output ack);
endinterface

// File: rtl/flit_source.sv
// Packet source for the two-phase flit channel: one head flit then BODY_FLITS
// body flits per accepted start, one flit outstanding at a time.
module flit_source #(
   parameter int BODY_FLITS = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pkt_start,
   input  logic [2:0]       pkt_dest,
   input  logic [6:0]       pkt_seed,
   output logic             pkt_busy,
   output logic             pkt_done,
   output logic [CNT_W-1:0] flit_cnt,
   flit_source_if.master    ch
);
   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t     state;
   logic       req;
   logic [7:0] flit;
   logic [7:0] remaining;
   logic [6:0] payload;

   assign ch.req  = req;
   assign ch.flit = flit;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         req       <= 1'b0;
         flit      <= 8'h00;
         remaining <= 8'h00;
         payload   <= 7'h00;
         pkt_busy  <= 1'b0;
         pkt_done  <= 1'b0;
         flit_cnt  <= '0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            IDLE: begin
               // Spurious ack toggles are ignored here: nothing is outstanding.
               if (pkt_start) begin
                  flit      <= {5'b10000, pkt_dest};
                  req       <= ~req;
                  payload   <= pkt_seed;
                  remaining <= 8'(BODY_FLITS);
                  pkt_busy  <= 1'b1;
                  state     <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ch.ack == req) begin
                  flit_cnt <= flit_cnt + CNT_W'(1);
                  if (remaining != 8'h00) begin
                     // Payload is 7 bits and wraps 127 -> 0 naturally.
                     flit      <= {1'b0, payload};
                     payload   <= payload + 7'd1;
                     req       <= ~req;
                     remaining <= remaining - 8'd1;
                  end else begin
                     pkt_done <= 1'b1;
                     pkt_busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
         endcase
      end
   end
endmodule
